// File: rtl/register_file_2r1w_pkg.sv
// Shared defaults and helpers for the 2-read/1-write register file.
package register_file_2r1w_pkg;

    localparam int unsigned DEFAULT_N = 4;
    localparam int unsigned DEFAULT_W = 16;

    function automatic int unsigned depth_of(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/register_file_2r1w_read_port.sv
// One combinational read port: zero register, write bypass, then array lookup.
module register_file_2r1w_read_port
    import register_file_2r1w_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N,
    parameter int unsigned W = DEFAULT_W
) (
    input  logic [N-1:0] addr,
    input  logic         we,
    input  logic [N-1:0] addr_rd,
    input  logic [W-1:0] data_in,
    input  logic [W-1:0] mem [depth_of(N)],
    output logic [W-1:0] data
);

    // NOTE: every path assigns data (default first), so no latch is inferred.
    always_comb begin
        data = '0;
        if (addr != '0) begin
            if (we && (addr == addr_rd)) begin
                data = data_in;
            end else begin
                data = mem[addr];
            end
        end
    end

endmodule

// File: rtl/register_file_2r1w.sv
// 2^N x W register file with x0 hardwired to zero, two async reads, one sync write.
module register_file_2r1w
    import register_file_2r1w_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N,
    parameter int unsigned W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [N-1:0] addr_rd,
    input  logic [N-1:0] addr_rs1,
    input  logic [N-1:0] addr_rs2,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] rs1,
    output logic [W-1:0] rs2
);

    localparam int unsigned DEPTH = depth_of(N);

    logic [W-1:0] mem [DEPTH];

    // NOTE: the whole array is cleared on async reset, which rules out a RAM
    // macro; a register file this small lives in flops anyway.
    // NOTE: sequential state uses <= so all words update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (addr_rd != '0)) begin
            mem[addr_rd] <= data_in;
        end
    end

    register_file_2r1w_read_port #(.N(N), .W(W)) u_port1 (
        .addr    (addr_rs1),
        .we      (we),
        .addr_rd (addr_rd),
        .data_in (data_in),
        .mem     (mem),
        .data    (rs1)
    );

    register_file_2r1w_read_port #(.N(N), .W(W)) u_port2 (
        .addr    (addr_rs2),
        .we      (we),
        .addr_rd (addr_rd),
        .data_in (data_in),
        .mem     (mem),
        .data    (rs2)
    );

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed bench for register_file_2r1w: reset, x0, fill/random read, bypass, mid-run reset.
module tb_register_file_2r1w;

    localparam int unsigned N = 4;
    localparam int unsigned W = 16;
    localparam int unsigned DEPTH = 1 << N;

    logic         clk = 1'b0;
    logic         rst;
    logic         we;
    logic [N-1:0] addr_rd;
    logic [N-1:0] addr_rs1;
    logic [N-1:0] addr_rs2;
    logic [W-1:0] data_in;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;

    logic [W-1:0] model [DEPTH];
    int n_pass  = 0;
    int n_total = 0;

    register_file_2r1w #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .addr_rd  (addr_rd),
        .addr_rs1 (addr_rs1),
        .addr_rs2 (addr_rs2),
        .data_in  (data_in),
        .rs1      (rs1),
        .rs2      (rs2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive a write mid-cycle, commit it on the next rising edge, drop we at the falling edge.
    task automatic write_reg(input logic [N-1:0] a, input logic [W-1:0] d);
        we = 1'b1;
        addr_rd = a;
        data_in = d;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        if (a != '0) model[a] = d;
    endtask

    task automatic sweep_zero(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            addr_rs1 = N'(i);
            addr_rs2 = N'(DEPTH - 1 - i);
            #1;
            check({tag, "_rs1"}, rs1, '0);
            check({tag, "_rs2"}, rs2, '0);
        end
    endtask

    initial begin
        logic [N-1:0] a1;
        logic [N-1:0] a2;

        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        rst = 1'b0;
        we = 1'b0;
        addr_rd = '0;
        addr_rs1 = '0;
        addr_rs2 = '0;
        data_in = '0;

        // Reset held 4 cycles; bypass still visible during reset, but the write is dropped.
        repeat (2) @(negedge clk);
        we = 1'b1;
        addr_rd = 4'd3;
        data_in = 16'hBEEF;
        addr_rs1 = 4'd3;
        addr_rs2 = 4'd4;
        #1;
        check("reset_bypass_rs1", rs1, 16'hBEEF);
        check("reset_bypass_rs2", rs2, '0);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("reset_write_ignored", rs1, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        sweep_zero("post_reset");

        // Register 0 is immune to writes and never bypassed.
        addr_rs1 = '0;
        addr_rs2 = '0;
        we = 1'b1;
        addr_rd = '0;
        data_in = '1;
        #1;
        check("x0_bypass_rs1", rs1, '0);
        check("x0_bypass_rs2", rs2, '0);
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("x0_after_rs1", rs1, '0);
        check("x0_after_rs2", rs2, '0);

        // Fill with distinct values: address in the top nibble guarantees uniqueness.
        for (int i = 1; i < DEPTH; i++) begin
            write_reg(N'(i), {4'(i), 12'($urandom)});
        end
        for (int k = 0; k < 512; k++) begin
            a1 = N'($urandom_range(DEPTH - 1, 0));
            a2 = N'($urandom_range(DEPTH - 1, 0));
            addr_rs1 = a1;
            addr_rs2 = a2;
            #1;
            check("rand_rs1", rs1, model[a1]);
            check("rand_rs2", rs2, model[a2]);
        end

        // Bypass with we=0 must not apply even when addresses match.
        addr_rd = 4'd9;
        data_in = 16'h0F0F;
        addr_rs1 = 4'd9;
        #1;
        check("no_bypass_we0", rs1, model[9]);

        // Bypass before the edge, array value after it.
        addr_rs1 = 4'd5;
        addr_rs2 = '0;
        we = 1'b1;
        addr_rd = 4'd5;
        data_in = 16'hA5A5;
        #1;
        check("bypass_pre_rs1", rs1, 16'hA5A5);
        check("bypass_pre_rs2", rs2, '0);
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        data_in = 16'h0000;
        model[5] = 16'hA5A5;
        #1;
        check("bypass_post_rs1", rs1, 16'hA5A5);

        // Same address on both ports, including while it is being written.
        addr_rs1 = 4'd7;
        addr_rs2 = 4'd7;
        we = 1'b1;
        addr_rd = 4'd7;
        data_in = 16'h1234;
        #1;
        check("same_pre_rs1", rs1, 16'h1234);
        check("same_pre_rs2", rs2, 16'h1234);
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        model[7] = 16'h1234;
        #1;
        check("same_post_rs1", rs1, 16'h1234);
        check("same_post_rs2", rs2, 16'h1234);
        addr_rs1 = 4'd15;
        #1;
        check("other_reg_intact", rs1, model[15]);

        // Mid-operation reset between edges clears the array immediately.
        #2;
        rst = 1'b0;
        sweep_zero("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sweep_zero("after_release");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
